fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
- Shares the single insert port of one FIFO instance among NUM_REQ producers.
- Uses round-robin arbitration with burst locking: a multi-beat transfer tagged by IN_last is never interleaved with another producer's beats.
- Admits a new burst only when the FIFO reports at least MIN_FREE free slots, so bursts cannot stall mid-transfer on a nearly-full queue.
- Sits directly in front of a FIFO, e.g. a load/store or fetch queue fed by several pipeline units.

Parameters:
- WIDTH, 32, payload width in bits.
- NUM_REQ, 3, number of requesters; must be 2 or more.
- FIFO_NUM, 4, entry count of the downstream FIFO. Sets FREE_W = $clog2(FIFO_NUM)+1.
- MIN_FREE, 1, minimum IN_fifoFree needed to start a new burst. Range 1..FIFO_NUM.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- IN_valid  in  NUM_REQ  per-requester beat valid.
- IN_data  in  NUM_REQ x WIDTH  per-requester payload.
- IN_last  in  NUM_REQ  beat is the final beat of its burst.
- OUT_ready  out  NUM_REQ  per-requester accept.
- IN_fifoFree  in  FREE_W  FIFO free-slot count.
- OUT_valid  out  1  to FIFO IN_valid.
- OUT_data  out  WIDTH  to FIFO IN_data.
- IN_ready  in  1  from FIFO OUT_ready.
- OUT_grantIdx  out  $clog2(NUM_REQ)  index of the current grantee; valid when OUT_valid=1.
- OUT_busy  out  1  high while a burst is locked.

Behaviour:
- State: fsm in {IDLE, LOCKED}, rrPtr (next-priority index), lockIdx.
- Reset values: fsm=IDLE, rrPtr=0, lockIdx=0.
- Reset consequences:
  - OUT_valid=0 and all OUT_ready=0 in the cycle after reset, unless inputs are valid.
  - OUT_busy=0; OUT_grantIdx=0.
- Reset mid-burst discards the lock. A partially transferred burst is the producer's responsibility.
- Beat accept: a beat is accepted when OUT_valid && IN_ready. The grantee sees OUT_ready[g]=IN_ready; all other OUT_ready bits are 0.
- OUT_ready does not depend on any IN_valid. This avoids a valid-to-ready loop across producers.
- IDLE:
  - Candidate g is the first i with IN_valid[i] set, scanning rrPtr, rrPtr+1, ... mod NUM_REQ.
  - Admission requires IN_fifoFree >= MIN_FREE. If not admitted, OUT_valid=0.
  - When admitted: OUT_valid=1 and OUT_data=IN_data[g]. All of this is combinational, with zero added latency.
  - OUT_ready[g]=IN_ready only when admitted. Otherwise all OUT_ready=0.
- IDLE, on accept with IN_last[g]=1: stay in IDLE; rrPtr <= (g+1) mod NUM_REQ.
- IDLE, on accept with IN_last[g]=0: go to LOCKED; lockIdx <= g. rrPtr is unchanged.
- LOCKED:
  - g=lockIdx; there is no credit check.
  - OUT_valid=IN_valid[lockIdx]. A producer bubble passes through as OUT_valid=0; the lock is held.
  - On accept with IN_last[lockIdx]=1: go to IDLE; rrPtr <= (lockIdx+1) mod NUM_REQ.
- Wrap-around: index NUM_REQ-1 plus 1 gives 0.
- Single requester: the same index may win again only if no other requester is valid.
- A valid producer with no IN_ready holds its beat. Producers must keep data stable until accepted, per the ready/valid rules.
- OUT_busy = (fsm==LOCKED).
- OUT_grantIdx = g, and is 0 when no candidate is valid.
- No storage of payload; all data paths are combinational muxes.

Optional Feature:
- Macro: FIFO_ARB_PRIO0_EN.
- Defined: in IDLE, requester 0 wins whenever IN_valid[0]=1, regardless of rrPtr.
  - A single-beat grant to requester 0 does not advance rrPtr.
  - A burst by requester 0 restores rrPtr unchanged when it ends.
  - An active LOCKED burst is never preempted.
- Undefined: pure round-robin as above.

Test Plan:
- After reset, IN_valid=3'b111, IN_last=3'b111, IN_ready=1, free=4 -> grants in order 0,1,2,0 on consecutive cycles; OUT_data matches each source.
- Requester 1 sends a 3-beat burst (last on beat 3) while requester 2 is valid throughout -> OUT_grantIdx=1 for 3 accepts, OUT_busy=1 for beats 2-3, then requester 2 granted.
- MIN_FREE=2, free=1, IN_valid[0]=1 -> OUT_valid=0, OUT_ready=0. Free becomes 2 -> beat accepted in that same cycle.
- LOCKED on requester 0, IN_valid[0]=0 for 2 cycles while requester 1 is valid -> OUT_valid=0, no grant to 1; lock kept until the last beat of 0.
- Assert rst during LOCKED beat 2 -> next cycle fsm=IDLE, rrPtr=0, OUT_busy=0; requester 2 alone valid -> granted immediately.
- With FIFO_ARB_PRIO0_EN, all valid and rrPtr=2 -> requester 0 granted while valid, rrPtr stays 2; after 0 drops, requester 2 granted next.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin, burst-locking arbiter for one FIFO insert port.
// Define FIFO_ARB_PRIO0_EN to give requester 0 fixed priority whenever a new burst is admitted.
module fifo_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NUM_REQ  = 3,
  parameter int FIFO_NUM = 4,
  parameter int MIN_FREE = 1,
  localparam int FREE_W  = $clog2(FIFO_NUM) + 1,
  localparam int GIDX_W  = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         IN_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   IN_data,
  input  logic [NUM_REQ-1:0]         IN_last,
  output logic [NUM_REQ-1:0]         OUT_ready,
  input  logic [FREE_W-1:0]          IN_fifoFree,
  output logic                       OUT_valid,
  output logic [WIDTH-1:0]           OUT_data,
  input  logic                       IN_ready,
  output logic [GIDX_W-1:0]          OUT_grantIdx,
  output logic                       OUT_busy
);

`ifdef FIFO_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              fsm_q, fsm_d;
  logic [GIDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GIDX_W-1:0]   lock_idx_q, lock_idx_d;

  logic                cand_found;
  logic [GIDX_W-1:0]   cand_idx;
  logic [GIDX_W-1:0]   grant_idx;
  logic                admit;
  logic                accept;

  function automatic logic [GIDX_W-1:0] next_idx(input logic [GIDX_W-1:0] v);
    if (v == GIDX_W'(NUM_REQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // First valid requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
  always_comb begin : cand_scan
    logic [GIDX_W:0] sum;
    sum        = '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (GIDX_W+1)'(k);
      if (sum >= (GIDX_W+1)'(NUM_REQ)) sum = sum - (GIDX_W+1)'(NUM_REQ);
      if (!cand_found && IN_valid[sum[GIDX_W-1:0]]) begin
        cand_found = 1'b1;
        cand_idx   = sum[GIDX_W-1:0];
      end
    end
    if (PRIO0 && IN_valid[0]) begin
      cand_found = 1'b1;
      cand_idx   = '0;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          if (IN_last[grant_idx]) begin
            if (!(PRIO0 && grant_idx == '0)) rr_ptr_d = next_idx(grant_idx);
          end else begin
            fsm_d      = LOCKED;
            lock_idx_d = grant_idx;
          end
        end
      end
      LOCKED: begin
        if (accept && IN_last[lock_idx_q]) begin
          fsm_d = IDLE;
          if (!(PRIO0 && lock_idx_q == '0)) rr_ptr_d = next_idx(lock_idx_q);
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Ready is keyed on the grant alone so a producer's valid never feeds another's ready.
  always_comb begin
    grant_idx = (fsm_q == LOCKED) ? lock_idx_q : cand_idx;
    admit     = cand_found && (IN_fifoFree >= FREE_W'(MIN_FREE));
    OUT_valid = (fsm_q == LOCKED) ? IN_valid[lock_idx_q] : admit;
    accept    = OUT_valid && IN_ready;
    OUT_ready = '0;
    if (fsm_q == LOCKED || admit) OUT_ready[grant_idx] = IN_ready;
    OUT_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == GIDX_W'(i)) OUT_data = IN_data[i*WIDTH +: WIDTH];
    end
    OUT_grantIdx = grant_idx;
    OUT_busy     = (fsm_q == LOCKED);
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed vector table, reset-mid-burst sequence and
// randomized run against a queue-free reference model of the arbiter.
module tb_fifo_rr_arbiter;
  localparam int WIDTH    = 32;
  localparam int NUM_REQ  = 3;
  localparam int FIFO_NUM = 4;
  localparam int MIN_FREE = 2;

`ifdef FIFO_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       in_valid;
  logic [NUM_REQ*WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]       in_last;
  logic [NUM_REQ-1:0]       out_ready;
  logic [2:0]               in_fifo_free;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     in_ready;
  logic [1:0]               out_grant_idx;
  logic                     out_busy;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .FIFO_NUM(FIFO_NUM), .MIN_FREE(MIN_FREE)
  ) dut (
    .clk(clk), .rst(rst),
    .IN_valid(in_valid), .IN_data(in_data), .IN_last(in_last),
    .OUT_ready(out_ready), .IN_fifoFree(in_fifo_free),
    .OUT_valid(out_valid), .OUT_data(out_data), .IN_ready(in_ready),
    .OUT_grantIdx(out_grant_idx), .OUT_busy(out_busy)
  );

  typedef struct {
    logic       rst;
    logic [2:0] v;
    logic [2:0] l;
    logic       rdy;
    logic [2:0] free;
    logic       ev;
    logic [2:0] er;
    logic [1:0] eg;
    logic       eb;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] src [NUM_REQ];

  bit m_locked;
  int m_lock;
  int m_rr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic r, input logic [2:0] v, input logic [2:0] l,
                               input logic rdy, input logic [2:0] free, input logic ev,
                               input logic [2:0] er, input logic [1:0] eg, input logic eb);
    vec_t x;
    x.rst = r; x.v = v; x.l = l; x.rdy = rdy; x.free = free;
    x.ev = ev; x.er = er; x.eg = eg; x.eb = eb;
    return x;
  endfunction

  task automatic drive(input logic r, input logic [2:0] v, input logic [2:0] l,
                       input logic rdy, input logic [2:0] free);
    rst = r; in_valid = v; in_last = l; in_ready = rdy; in_fifo_free = free;
    for (int i = 0; i < NUM_REQ; i++) in_data[i*WIDTH +: WIDTH] = src[i];
  endtask

  task automatic run_row(input string tag, input vec_t x);
    drive(x.rst, x.v, x.l, x.rdy, x.free);
    #4;
    check({tag, " valid"}, 64'(out_valid), 64'(x.ev));
    check({tag, " ready"}, 64'(out_ready), 64'(x.er));
    check({tag, " busy"}, 64'(out_busy), 64'(x.eb));
    if (x.ev) begin
      check({tag, " grant"}, 64'(out_grant_idx), 64'(x.eg));
      check({tag, " data"}, 64'(out_data), 64'(src[x.eg]));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    src[0] = 32'h1111_0000;
    src[1] = 32'h2222_0001;
    src[2] = 32'h3333_0002;
    drive(1'b1, 3'b000, 3'b000, 1'b1, 3'd4);
    @(posedge clk);
    @(posedge clk);
    #1;

`ifndef FIFO_ARB_PRIO0_EN
    //            rst  valid   last    rdy  free  ev   ready   g  busy
    tbl.push_back(row(0, 3'b000, 3'b000, 1, 3'd4, 0, 3'b000, 0, 0));
    tbl.push_back(row(0, 3'b111, 3'b111, 1, 3'd4, 1, 3'b001, 0, 0));
    tbl.push_back(row(0, 3'b111, 3'b111, 1, 3'd4, 1, 3'b010, 1, 0));
    tbl.push_back(row(0, 3'b111, 3'b111, 1, 3'd4, 1, 3'b100, 2, 0));
    tbl.push_back(row(0, 3'b111, 3'b111, 1, 3'd4, 1, 3'b001, 0, 0));
    tbl.push_back(row(0, 3'b110, 3'b000, 1, 3'd4, 1, 3'b010, 1, 0));
    tbl.push_back(row(0, 3'b110, 3'b000, 1, 3'd4, 1, 3'b010, 1, 1));
    tbl.push_back(row(0, 3'b110, 3'b010, 1, 3'd4, 1, 3'b010, 1, 1));
    tbl.push_back(row(0, 3'b100, 3'b100, 1, 3'd4, 1, 3'b100, 2, 0));
    tbl.push_back(row(0, 3'b001, 3'b001, 1, 3'd1, 0, 3'b000, 0, 0));
    tbl.push_back(row(0, 3'b001, 3'b001, 1, 3'd2, 1, 3'b001, 0, 0));
    tbl.push_back(row(0, 3'b001, 3'b000, 1, 3'd4, 1, 3'b001, 0, 0));
    tbl.push_back(row(0, 3'b010, 3'b010, 1, 3'd4, 0, 3'b001, 0, 1));
    tbl.push_back(row(0, 3'b010, 3'b010, 1, 3'd4, 0, 3'b001, 0, 1));
    tbl.push_back(row(0, 3'b011, 3'b011, 1, 3'd4, 1, 3'b001, 0, 1));
    tbl.push_back(row(0, 3'b010, 3'b010, 1, 3'd4, 1, 3'b010, 1, 0));
    tbl.push_back(row(0, 3'b111, 3'b111, 0, 3'd4, 1, 3'b000, 2, 0));
    tbl.push_back(row(0, 3'b111, 3'b111, 1, 3'd4, 1, 3'b100, 2, 0));
    tbl.push_back(row(0, 3'b001, 3'b000, 1, 3'd4, 1, 3'b001, 0, 0));
    tbl.push_back(row(0, 3'b001, 3'b001, 1, 3'd0, 1, 3'b001, 0, 1));
    for (int i = 0; i < tbl.size(); i++) run_row($sformatf("row%0d", i), tbl[i]);
`endif

    // Reset in the middle of requester 1's burst: lock and pointer both drop.
    run_row("rstseq lock",  row(0, 3'b010, 3'b000, 1, 3'd4, 1, 3'b010, 1, 0));
    run_row("rstseq beat2", row(1, 3'b010, 3'b000, 1, 3'd4, 1, 3'b010, 1, 1));
    run_row("rstseq alone", row(0, 3'b100, 3'b100, 0, 3'd4, 1, 3'b000, 2, 0));
    run_row("rstseq ptr0",  row(0, 3'b101, 3'b101, 1, 3'd4, 1, 3'b001, 0, 0));

    drive(1'b1, 3'b000, 3'b000, 1'b1, 3'd4);
    @(posedge clk);
    #1;
    m_locked = 1'b0;
    m_lock   = 0;
    m_rr     = 0;

    for (int c = 0; c < 600; c++) begin
      logic [2:0] v, l, free, er;
      logic       rdy, r, ev, open;
      bit         found;
      int         cand, g;
      v    = 3'($urandom);
      l    = 3'($urandom);
      rdy  = ($urandom % 4) != 0;
      free = 3'($urandom_range(0, 4));
      r    = ($urandom % 64) == 0;
      for (int i = 0; i < NUM_REQ; i++) src[i] = $urandom;

      found = 1'b0;
      cand  = 0;
      if (PRIO0 && v[0]) begin
        found = 1'b1;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int i;
          i = (m_rr + k) % NUM_REQ;
          if (!found && v[i]) begin
            found = 1'b1;
            cand  = i;
          end
        end
      end
      g    = m_locked ? m_lock : cand;
      open = m_locked || (found && free >= MIN_FREE);
      ev   = m_locked ? v[m_lock] : (found && free >= MIN_FREE);
      er   = (open && rdy) ? 3'(1 << g) : 3'b000;

      drive(r, v, l, rdy, free);
      #4;
      check($sformatf("rand%0d valid", c), 64'(out_valid), 64'(ev));
      check($sformatf("rand%0d ready", c), 64'(out_ready), 64'(er));
      check($sformatf("rand%0d busy", c), 64'(out_busy), 64'(m_locked));
      check($sformatf("rand%0d grant", c), 64'(out_grant_idx), 64'(g));
      if (ev) check($sformatf("rand%0d data", c), 64'(out_data), 64'(src[g]));

      if (r) begin
        m_locked = 1'b0;
        m_lock   = 0;
        m_rr     = 0;
      end else if (ev && rdy) begin
        if (l[g]) begin
          m_locked = 1'b0;
          if (!(PRIO0 && g == 0)) m_rr = (g + 1) % NUM_REQ;
        end else if (!m_locked) begin
          m_locked = 1'b1;
          m_lock   = g;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
